// File: rtl/sequence_checker.sv
// Purpose: receive-side checker for the 1,3,4,6,8,10,12,14 sequence; hunts, verifies, locks, flags errors.
// Latency: every output is registered and reflects a valid sample one clk after its edge.
// Backpressure: none; in_valid qualifies each sample and idle cycles freeze all state.
//
// Ports:
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   in_valid, in_data   qualified 4-bit received sequence value
//   clear_err           synchronous clear of err_count (wins over a same-cycle increment)
//   locked              high while the checker is in LOCKED
//   seq_error           one-cycle pulse on each mismatch while locked
//   expected            value predicted for the next valid sample
//   err_count           saturating count of locked-state mismatches
//   wrap_count          completed locked sequence periods, modulo 2^ERR_W
//                       (present only when SEQ_CHK_WRAP_CNT_EN is defined)
module sequence_checker #(
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 2,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   input  logic             clear_err,
   output logic             locked,
   output logic             seq_error,
   output logic [3:0]       expected,
   output logic [ERR_W-1:0] err_count
`ifdef SEQ_CHK_WRAP_CNT_EN
   ,
   output logic [ERR_W-1:0] wrap_count
`endif
);

   typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

   localparam logic [3:0] LP_LOCK = 4'(LOCK_CNT);
   localparam logic [3:0] LP_LOSS = 4'(LOSS_CNT);

   function automatic logic [3:0] f_next(input logic [3:0] v);
      case (v)
         4'd1:    f_next = 4'd3;
         4'd3:    f_next = 4'd4;
         4'd4:    f_next = 4'd6;
         4'd6:    f_next = 4'd8;
         4'd8:    f_next = 4'd10;
         4'd10:   f_next = 4'd12;
         4'd12:   f_next = 4'd14;
         default: f_next = 4'd1;
      endcase
   endfunction

   function automatic logic f_legal(input logic [3:0] v);
      case (v)
         4'd1, 4'd3, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14: f_legal = 1'b1;
         default:                                           f_legal = 1'b0;
      endcase
   endfunction

   state_t           r_state;
   logic [3:0]       r_match_run;
   logic [3:0]       r_miss_run;
   logic [3:0]       r_expected;
   logic [ERR_W-1:0] r_err_count;
   logic             r_seq_error;

   state_t           w_state_nxt;
   logic [3:0]       w_match_nxt;
   logic [3:0]       w_miss_nxt;
   logic [3:0]       w_exp_nxt;
   logic             w_seqerr_nxt;
   logic             w_err_inc;
   logic [ERR_W-1:0] w_err_nxt;
   logic             w_match;

   assign w_match = (in_data == r_expected);

   always_comb begin
      w_state_nxt  = r_state;
      w_match_nxt  = r_match_run;
      w_miss_nxt   = r_miss_run;
      w_exp_nxt    = r_expected;
      w_seqerr_nxt = 1'b0;
      w_err_inc    = 1'b0;
      if (in_valid) begin
         case (r_state)
            S_HUNT: begin
               if (f_legal(in_data)) begin
                  w_exp_nxt   = f_next(in_data);
                  w_match_nxt = 4'd1;
                  if (LOCK_CNT == 1) begin
                     w_state_nxt = S_LOCKED;
                     w_miss_nxt  = 4'd0;
                  end else begin
                     w_state_nxt = S_VERIFY;
                  end
               end
            end
            S_VERIFY: begin
               if (w_match) begin
                  w_match_nxt = r_match_run + 4'd1;
                  w_exp_nxt   = f_next(in_data);
                  if (r_match_run + 4'd1 == LP_LOCK) begin
                     w_state_nxt = S_LOCKED;
                     w_miss_nxt  = 4'd0;
                  end
               end else if (f_legal(in_data)) begin
                  // Resync: the wrong-but-legal sample becomes a fresh first sample.
                  w_match_nxt = 4'd1;
                  w_exp_nxt   = f_next(in_data);
               end else begin
                  w_state_nxt = S_HUNT;
                  w_match_nxt = 4'd0;
               end
            end
            S_LOCKED: begin
               // Flywheel: the prediction advances from itself, never from a bad sample.
               w_exp_nxt = f_next(r_expected);
               if (w_match) begin
                  w_miss_nxt = 4'd0;
               end else begin
                  w_seqerr_nxt = 1'b1;
                  w_err_inc    = 1'b1;
                  w_miss_nxt   = r_miss_run + 4'd1;
                  if (r_miss_run + 4'd1 == LP_LOSS) begin
                     w_state_nxt = S_HUNT;
                     w_miss_nxt  = 4'd0;
                     w_match_nxt = 4'd0;
                  end
               end
            end
            default: w_state_nxt = S_HUNT;
         endcase
      end
   end

   always_comb begin
      w_err_nxt = r_err_count;
      if (clear_err)
         w_err_nxt = '0;
      else if (w_err_inc && !(&r_err_count))
         w_err_nxt = r_err_count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_HUNT;
         r_match_run <= 4'd0;
         r_miss_run  <= 4'd0;
         r_expected  <= 4'd1;
         r_err_count <= '0;
         r_seq_error <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_match_run <= w_match_nxt;
         r_miss_run  <= w_miss_nxt;
         r_expected  <= w_exp_nxt;
         r_err_count <= w_err_nxt;
         r_seq_error <= w_seqerr_nxt;
      end
   end

`ifdef SEQ_CHK_WRAP_CNT_EN
   // r_last14 remembers that the previous valid sample was a matched 14 while locked,
   // so a following matched 1 closes one full period.
   logic             r_last14;
   logic [ERR_W-1:0] r_wrap_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_last14     <= 1'b0;
         r_wrap_count <= '0;
      end else if (in_valid) begin
         r_last14 <= (r_state == S_LOCKED) && w_match && (in_data == 4'd14);
         if ((r_state == S_LOCKED) && w_match && (in_data == 4'd1) && r_last14)
            r_wrap_count <= r_wrap_count + 1'b1;
      end
   end

   assign wrap_count = r_wrap_count;
`endif

   assign locked    = (r_state == S_LOCKED);
   assign seq_error = r_seq_error;
   assign expected  = r_expected;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_sequence_checker.sv
// Purpose: self-checking bench for sequence_checker (LOCK_CNT=3, LOSS_CNT=2, ERR_W=8).
// Latency: each driven cycle queues its expected outputs; a monitor compares #1 after the next edge.
// Backpressure: none; the stimulus drives one vector per clock.
module tb_sequence_checker;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;
   logic       clear_err = 1'b0;
   logic       locked;
   logic       seq_error;
   logic [3:0] expected;
   logic [7:0] err_count;
`ifdef SEQ_CHK_WRAP_CNT_EN
   logic [7:0] wrap_count;
`endif

   sequence_checker #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clear_err (clear_err),
      .locked    (locked),
      .seq_error (seq_error),
      .expected  (expected),
      .err_count (err_count)
`ifdef SEQ_CHK_WRAP_CNT_EN
      ,
      .wrap_count(wrap_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       lk;
      logic       se;
      logic [3:0] ex;
      logic [7:0] ec;
      bit         wchk;
      logic [7:0] wr;
      string      nm;
   } exp_t;

   exp_t       q[$];
   int         n_total = 0;
   int         n_pass  = 0;
   bit         g_wchk  = 1'b0;
   logic [7:0] g_wr    = 8'd0;
   logic [3:0] sq[8] = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};

   task automatic cyc(input logic rst, input logic v, input logic [3:0] d, input logic clr,
                      input logic lk, input logic se, input logic [3:0] ex,
                      input logic [7:0] ec, input string nm);
      exp_t e;
      @(negedge clk);
      reset_n   = rst;
      in_valid  = v;
      in_data   = d;
      clear_err = clr;
      e.lk = lk; e.se = se; e.ex = ex; e.ec = ec;
      e.wchk = g_wchk; e.wr = g_wr; e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: one expectation per clock, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if ({locked, seq_error, expected, err_count} === {e.lk, e.se, e.ex, e.ec})
               n_pass++;
            else
               $display("FAIL %s: got lk=%b se=%b ex=%0d ec=%0d, want lk=%b se=%b ex=%0d ec=%0d",
                        e.nm, locked, seq_error, expected, err_count, e.lk, e.se, e.ex, e.ec);
`ifdef SEQ_CHK_WRAP_CNT_EN
            if (e.wchk) begin
               n_total++;
               if (wrap_count === e.wr)
                  n_pass++;
               else
                  $display("FAIL %s wrap_count: got %0d, want %0d", e.nm, wrap_count, e.wr);
            end
`endif
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
      $fatal(1, "timeout");
   end

   initial begin
      int p;
      logic [7:0] ec;

      // Reset state
      g_wchk = 1'b1; g_wr = 8'd0;
      cyc(0, 0, 4'd0, 0, 0, 0, 4'd1, 8'd0, "reset0");
      cyc(0, 1, 4'd1, 0, 0, 0, 4'd1, 8'd0, "reset1");

      // Clean stream of 32 samples: lock after the third; periods close at samples 8, 16, 24.
      for (int i = 0; i < 32; i++) begin
         g_wr = (i >= 24) ? 8'd3 : (i >= 16) ? 8'd2 : (i >= 8) ? 8'd1 : 8'd0;
         cyc(1, 1, sq[i % 8], 0, (i >= 2), 0, sq[(i + 1) % 8], 8'd0, $sformatf("clean_%0d", i));
      end

      // Reset mid-lock, then illegal values in HUNT, then lock on 8,10,12
      g_wr = 8'd0;
      cyc(0, 0, 4'd0, 0, 0, 0, 4'd1, 8'd0, "rst_midlock");
      g_wchk = 1'b0;
      cyc(1, 1, 4'd2,  0, 0, 0, 4'd1,  8'd0, "hunt_2");
      cyc(1, 1, 4'd5,  0, 0, 0, 4'd1,  8'd0, "hunt_5");
      cyc(1, 1, 4'd15, 0, 0, 0, 4'd1,  8'd0, "hunt_15");
      cyc(1, 1, 4'd8,  0, 0, 0, 4'd10, 8'd0, "ver_8");
      cyc(1, 1, 4'd10, 0, 0, 0, 4'd12, 8'd0, "ver_10");
      cyc(1, 1, 4'd12, 0, 1, 0, 4'd14, 8'd0, "lock_12");

      // Single corrupt value (9 instead of 10)
      cyc(1, 1, 4'd14, 0, 1, 0, 4'd1,  8'd0, "lk_14");
      cyc(1, 1, 4'd1,  0, 1, 0, 4'd3,  8'd0, "lk_1");
      cyc(1, 1, 4'd3,  0, 1, 0, 4'd4,  8'd0, "lk_3");
      cyc(1, 1, 4'd4,  0, 1, 0, 4'd6,  8'd0, "lk_4");
      cyc(1, 1, 4'd6,  0, 1, 0, 4'd8,  8'd0, "lk_6");
      cyc(1, 1, 4'd8,  0, 1, 0, 4'd10, 8'd0, "lk_8");
      cyc(1, 1, 4'd9,  0, 1, 1, 4'd12, 8'd1, "bad_9");
      cyc(1, 1, 4'd12, 0, 1, 0, 4'd14, 8'd1, "after_bad_12");
      cyc(1, 1, 4'd14, 0, 1, 0, 4'd1,  8'd1, "after_bad_14");

      // Two consecutive bad values drop lock on the second error
      cyc(1, 1, 4'd5,  0, 1, 1, 4'd3,  8'd2, "miss1");
      cyc(1, 1, 4'd7,  0, 0, 1, 4'd4,  8'd3, "miss2_unlock");
      cyc(1, 1, 4'd2,  0, 0, 0, 4'd4,  8'd3, "hunt_after_loss");
      cyc(1, 1, 4'd6,  0, 0, 0, 4'd8,  8'd3, "relock_6");
      cyc(1, 1, 4'd8,  0, 0, 0, 4'd10, 8'd3, "relock_8");
      cyc(1, 1, 4'd10, 0, 1, 0, 4'd12, 8'd3, "relock_10");

      // Gaps: expected advances only on valid cycles
      cyc(1, 0, 4'd5,  0, 1, 0, 4'd12, 8'd3, "gap_a");
      cyc(1, 1, 4'd12, 0, 1, 0, 4'd14, 8'd3, "gap_v12");
      cyc(1, 0, 4'd0,  0, 1, 0, 4'd14, 8'd3, "gap_b");
      cyc(1, 1, 4'd14, 0, 1, 0, 4'd1,  8'd3, "gap_v14");
      cyc(1, 0, 4'd9,  0, 1, 0, 4'd1,  8'd3, "gap_c");
      cyc(1, 1, 4'd1,  0, 1, 0, 4'd3,  8'd3, "gap_v1");

      // Clear coinciding with a mismatch: clear wins
      cyc(1, 1, 4'd7,  1, 1, 1, 4'd4,  8'd0, "clr_with_err");
      cyc(1, 1, 4'd4,  0, 1, 0, 4'd6,  8'd0, "after_clr");

      // Saturation: alternate bad/good so lock holds while err_count climbs to 255
      p = 3;
      for (int i = 0; i < 256; i++) begin
         ec = (i >= 255) ? 8'd255 : 8'(i + 1);
         p = (p + 1) % 8;
         cyc(1, 1, 4'd0, 0, 1, 1, sq[p], ec, $sformatf("sat_bad_%0d", i));
         cyc(1, 1, sq[p], 0, 1, 0, sq[(p + 1) % 8], ec, $sformatf("sat_good_%0d", i));
         p = (p + 1) % 8;
      end

      // Reset with non-zero error count, then a first legal sample
      cyc(0, 1, 4'd3, 0, 0, 0, 4'd1, 8'd0, "rst_sat");
      cyc(1, 1, 4'd3, 0, 0, 0, 4'd4, 8'd0, "post_rst_3");

      begin
         int budget = 20;
         while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         @(negedge clk);
         if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
